// File: rtl/reset_seq_pkg.sv
// Shared definitions for the processor reset sequencer: state encoding,
// reset_count width and the counter width helper.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_INIT    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } seq_state_e;

  localparam int unsigned RESET_COUNT_W   = 8;
  localparam logic [7:0]  RESET_COUNT_MAX = 8'd255;

  // Width able to hold max(hold_cycles, init_timeout)-1, never narrower than 1.
  function automatic int unsigned seq_cnt_width(input int unsigned hold_cycles,
                                                input int unsigned init_timeout);
    int unsigned m;
    m = (hold_cycles > init_timeout) ? hold_cycles : init_timeout;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset synchronizer: asserts asynchronously, releases after STAGES rising edges.
module rst_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic arst_n_i,
  output logic rst_n_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], 1'b1};
    end
  end

  assign rst_n_o = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Sequenced active-low reset for the pipeline: hold, memory init handshake,
// one-cycle release, then run. Soft reset re-runs the sequence from RUN.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES  = 4,
  parameter int unsigned INIT_TIMEOUT = 256,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       soft_rst_req,
  input  logic       init_ack,
  output logic       proc_rst_n,
  output logic       mem_init_req,
  output logic       running,
  output logic       init_timeout,
  output logic [7:0] reset_count
);

  localparam int unsigned CNT_W = seq_cnt_width(HOLD_CYCLES, INIT_TIMEOUT);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(INIT_TIMEOUT - 1);

  logic fsm_rst_n;

  rst_sync #(
    .STAGES(SYNC_STAGES)
  ) u_rst_sync (
    .clk_i   (clk),
    .arst_n_i(reset),
    .rst_n_o (fsm_rst_n)
  );

  seq_state_e                 state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [CNT_W-1:0]           tcnt_q, tcnt_d;
  logic                       soft_req_q, soft_req_d;
  logic                       proc_rst_n_q, proc_rst_n_d;
  logic                       mem_init_req_q, mem_init_req_d;
  logic                       running_q, running_d;
  logic                       init_timeout_q, init_timeout_d;
  logic [RESET_COUNT_W-1:0]   reset_count_q, reset_count_d;

  always_ff @(posedge clk or negedge fsm_rst_n) begin
    if (!fsm_rst_n) begin
      state_q        <= ST_ASSERT;
      cnt_q          <= '0;
      tcnt_q         <= '0;
      soft_req_q     <= 1'b0;
      proc_rst_n_q   <= 1'b0;
      mem_init_req_q <= 1'b0;
      running_q      <= 1'b0;
      init_timeout_q <= 1'b0;
      reset_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      tcnt_q         <= tcnt_d;
      soft_req_q     <= soft_req_d;
      proc_rst_n_q   <= proc_rst_n_d;
      mem_init_req_q <= mem_init_req_d;
      running_q      <= running_d;
      init_timeout_q <= init_timeout_d;
      reset_count_q  <= reset_count_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    tcnt_d         = tcnt_q;
    soft_req_d     = 1'b0;
    init_timeout_d = init_timeout_q;
    reset_count_d  = reset_count_q;

    case (state_q)
      ST_ASSERT: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_INIT;
          cnt_d   = '0;
          tcnt_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_INIT: begin
        // Ack takes priority over a timeout landing on the same cycle.
        if (init_ack) begin
          state_d = ST_RELEASE;
        end else if (tcnt_q == TIMEOUT_LAST) begin
          state_d        = ST_RELEASE;
          init_timeout_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        state_d = ST_RUN;
        if (reset_count_q != RESET_COUNT_MAX) begin
          reset_count_d = reset_count_q + 8'd1;
        end
      end
      ST_RUN: begin
        // The request is registered first, so the drop lands one edge after sampling.
        soft_req_d = soft_rst_req;
        if (soft_req_q) begin
          state_d    = ST_ASSERT;
          cnt_d      = '0;
          soft_req_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_ASSERT;
        cnt_d   = '0;
      end
    endcase

    proc_rst_n_d   = (state_d == ST_RUN);
    running_d      = (state_d == ST_RUN);
    mem_init_req_d = (state_d == ST_INIT);
  end

  assign proc_rst_n   = proc_rst_n_q;
  assign mem_init_req = mem_init_req_q;
  assign running      = running_q;
  assign init_timeout = init_timeout_q;
  assign reset_count  = reset_count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with HOLD_CYCLES=4, INIT_TIMEOUT=8, SYNC_STAGES=2.
module tb_reset_sequencer;

  logic       clk;
  logic       reset;
  logic       soft_rst_req;
  logic       init_ack;
  logic       proc_rst_n;
  logic       mem_init_req;
  logic       running;
  logic       init_timeout;
  logic [7:0] reset_count;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_count;

  reset_sequencer #(
    .HOLD_CYCLES (4),
    .INIT_TIMEOUT(8),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .soft_rst_req(soft_rst_req),
    .init_ack    (init_ack),
    .proc_rst_n  (proc_rst_n),
    .mem_init_req(mem_init_req),
    .running     (running),
    .init_timeout(init_timeout),
    .reset_count (reset_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    soft_rst_req = 1'b0;
    init_ack     = 1'b1;
    reset        = 1'b1;
    #2 reset = 1'b0;
    tick(2);
    check("rst_proc_rst_n", 32'(proc_rst_n), 32'd0);
    check("rst_mem_init_req", 32'(mem_init_req), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_init_timeout", 32'(init_timeout), 32'd0);
    check("rst_reset_count", 32'(reset_count), 32'd0);

    // Power-on with ack tied high; reset rises right after edge 0.
    @(posedge clk);
    #1 reset = 1'b1;
    tick(5);
    check("po_e5_mem", 32'(mem_init_req), 32'd0);
    tick(1);
    check("po_e6_mem", 32'(mem_init_req), 32'd1);
    check("po_e6_proc", 32'(proc_rst_n), 32'd0);
    tick(1);
    check("po_e7_mem", 32'(mem_init_req), 32'd0);
    check("po_e7_proc", 32'(proc_rst_n), 32'd0);
    tick(1);
    check("po_e8_proc", 32'(proc_rst_n), 32'd1);
    check("po_e8_running", 32'(running), 32'd1);
    check("po_e8_count", 32'(reset_count), 32'd1);

    // Soft reset sampled at edge 9; INIT at edge 14.
    soft_rst_req = 1'b1;
    tick(1);
    soft_rst_req = 1'b0;
    check("sr_e9_proc", 32'(proc_rst_n), 32'd1);
    tick(1);
    check("sr_e10_proc", 32'(proc_rst_n), 32'd0);
    check("sr_e10_running", 32'(running), 32'd0);
    check("sr_e10_count", 32'(reset_count), 32'd1);
    init_ack = 1'b0;
    tick(3);
    check("sr_e13_mem", 32'(mem_init_req), 32'd0);
    tick(1);
    check("sr_e14_mem", 32'(mem_init_req), 32'd1);
    // Soft pulse during INIT must be ignored.
    soft_rst_req = 1'b1;
    tick(1);
    soft_rst_req = 1'b0;
    tick(1);
    check("sr_init_pulse_mem", 32'(mem_init_req), 32'd1);
    check("sr_init_pulse_proc", 32'(proc_rst_n), 32'd0);
    init_ack = 1'b1;
    tick(1);
    check("sr_e17_mem", 32'(mem_init_req), 32'd0);
    check("sr_e17_proc", 32'(proc_rst_n), 32'd0);
    tick(1);
    check("sr_e18_proc", 32'(proc_rst_n), 32'd1);
    check("sr_e18_running", 32'(running), 32'd1);
    check("sr_e18_count", 32'(reset_count), 32'd2);
    check("sr_e18_timeout", 32'(init_timeout), 32'd0);

    // Ack never arrives: INIT entered at edge 24, RELEASE at 32, RUN at 33.
    init_ack = 1'b0;
    soft_rst_req = 1'b1;
    tick(1);
    soft_rst_req = 1'b0;
    tick(1);
    check("to_e20_proc", 32'(proc_rst_n), 32'd0);
    tick(4);
    check("to_e24_mem", 32'(mem_init_req), 32'd1);
    tick(7);
    check("to_e31_mem", 32'(mem_init_req), 32'd1);
    check("to_e31_timeout", 32'(init_timeout), 32'd0);
    tick(1);
    check("to_e32_mem", 32'(mem_init_req), 32'd0);
    check("to_e32_timeout", 32'(init_timeout), 32'd1);
    check("to_e32_proc", 32'(proc_rst_n), 32'd0);
    tick(1);
    check("to_e33_proc", 32'(proc_rst_n), 32'd1);
    check("to_e33_count", 32'(reset_count), 32'd3);

    // Timeout flag survives a soft reset.
    init_ack = 1'b1;
    soft_rst_req = 1'b1;
    tick(1);
    soft_rst_req = 1'b0;
    tick(1);
    check("sticky_assert_proc", 32'(proc_rst_n), 32'd0);
    check("sticky_assert_timeout", 32'(init_timeout), 32'd1);
    tick(6);
    check("sticky_run_proc", 32'(proc_rst_n), 32'd1);
    check("sticky_run_count", 32'(reset_count), 32'd4);
    check("sticky_run_timeout", 32'(init_timeout), 32'd1);

    // Block reset dropped mid-INIT clears outputs without a clock edge.
    init_ack = 1'b0;
    soft_rst_req = 1'b1;
    tick(1);
    soft_rst_req = 1'b0;
    tick(6);
    check("mid_init_mem", 32'(mem_init_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async_mem", 32'(mem_init_req), 32'd0);
    check("async_proc", 32'(proc_rst_n), 32'd0);
    check("async_running", 32'(running), 32'd0);
    check("async_timeout", 32'(init_timeout), 32'd0);
    check("async_count", 32'(reset_count), 32'd0);

    // Ack arrives on the 8th INIT cycle, same cycle as the timeout.
    @(posedge clk);
    #1 reset = 1'b1;
    tick(13);
    check("tie_e13_mem", 32'(mem_init_req), 32'd1);
    init_ack = 1'b1;
    tick(1);
    check("tie_e14_mem", 32'(mem_init_req), 32'd0);
    check("tie_e14_timeout", 32'(init_timeout), 32'd0);
    tick(1);
    check("tie_e15_proc", 32'(proc_rst_n), 32'd1);
    check("tie_e15_running", 32'(running), 32'd1);
    check("tie_e15_count", 32'(reset_count), 32'd1);
    check("tie_e15_timeout", 32'(init_timeout), 32'd0);

    // Saturation: 256 soft-reset sequences.
    exp_count = 8'd1;
    for (int i = 0; i < 256; i++) begin
      soft_rst_req = 1'b1;
      tick(1);
      soft_rst_req = 1'b0;
      tick(7);
      if (exp_count != 8'd255) exp_count = exp_count + 8'd1;
      check("sat_count", 32'(reset_count), 32'(exp_count));
    end
    check("sat_running", 32'(running), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
